// File: rtl/overlay_writer.sv
// Overlay write-stream consumer: start/done pass handshake plus a beat FIFO feeding a byte-masked
// frame-buffer write port. Define OVERLAY_WRITER_STATS_EN to add per-pass write statistics.
module overlay_writer #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned MEM_ADDR_WIDTH = 18,
   parameter int unsigned FRAME0_BASE    = 0,
   parameter int unsigned FRAME1_BASE    = 120000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      trigger,
   output logic                      busy,
   output logic                      start,
   input  logic                      start_ack,
   input  logic                      done,
   output logic                      done_ack,
   input  logic [53:0]               din,
   input  logic                      din_valid,
   output logic                      din_ready,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]               mem_wdata,
   output logic [3:0]                mem_wmask
`ifdef OVERLAY_WRITER_STATS_EN
   ,
   output logic [16:0]               pass_beats,
   output logic                      pass_valid
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [MEM_ADDR_WIDTH-1:0] BASE0 = MEM_ADDR_WIDTH'(FRAME0_BASE);
   localparam logic [MEM_ADDR_WIDTH-1:0] BASE1 = MEM_ADDR_WIDTH'(FRAME1_BASE);

   typedef enum logic [2:0] {StIdle, StStart, StRun, StDrain, StAck} state_t;

   state_t           state;
   logic [53:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;
   logic [53:0]      head;

   // Fullness alone gates the push, so a same-cycle pop never frees a slot early.
   assign din_ready = (count != FULL_CNT);
   assign mem_valid = (count != '0);
   assign push      = din_valid & din_ready;
   assign pop       = mem_valid & mem_ready;

   assign head      = fifo_mem[rd_ptr];
   assign mem_wmask = head[53:50];
   assign mem_wdata = head[31:0];
   assign mem_addr  = (head[49] ? BASE1 : BASE0) + MEM_ADDR_WIDTH'(head[48:32]);

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= StIdle;
         start    <= 1'b0;
         done_ack <= 1'b0;
         busy     <= 1'b0;
      end else begin
         done_ack <= 1'b0;
         unique case (state)
            StIdle: begin
               if (trigger) begin
                  state <= StStart;
                  start <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            StStart: begin
               if (start_ack) begin
                  state <= StRun;
                  start <= 1'b0;
               end
            end
            StRun: begin
               if (done) begin
                  state <= StDrain;
               end
            end
            StDrain: begin
               // Empty FIFO means nothing is left on the memory port either.
               if (!mem_valid) begin
                  state    <= StAck;
                  done_ack <= 1'b1;
               end
            end
            StAck: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
            default: begin
               state <= StIdle;
               start <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef OVERLAY_WRITER_STATS_EN
   logic [16:0] beat_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         beat_cnt   <= '0;
         pass_beats <= '0;
         pass_valid <= 1'b0;
      end else begin
         pass_valid <= 1'b0;
         if (state == StIdle && trigger) begin
            beat_cnt <= '0;
         end else if (state != StIdle && pop) begin
            beat_cnt <= beat_cnt + 17'd1;
         end
         // Published on entry to ACK so pass_valid coincides with done_ack.
         if (state == StDrain && !mem_valid) begin
            pass_beats <= beat_cnt;
            pass_valid <= 1'b1;
         end
      end
   end
`else
   // Statistics build option off: no pass counter or stats outputs.
`endif

endmodule

// File: doc/overlay_writer.md
Name: overlay_writer

Overview:
- Consumer end of the overlay/pattern generator write stream.
- Initiates a generator pass with a start/start_ack handshake.
- Buffers incoming 54-bit {mask, frame, addr, pixel} write beats in a small FIFO and issues byte-masked 32-bit writes into one of two frame buffers.
- Closes the pass with done/done_ack. Sits between the overlay generators and the frame-buffer memory write port.

Parameters:
- FIFO_DEPTH, 8, number of 54-bit beats buffered; power of two, minimum 2.
- MEM_ADDR_WIDTH, 18, word-address width of the memory write port.
- FRAME0_BASE, 0, word base address of the frame-0 buffer.
- FRAME1_BASE, 120000, word base address of the frame-1 buffer.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- trigger  input  1  one-cycle request to run one generator pass (e.g. vsync).
- busy  output  1  high whenever the FSM is not IDLE.
- start  output  1  pass request to the generator.
- start_ack  input  1  generator acknowledge of start.
- done  input  1  generator end-of-pass flag; held until acknowledged.
- done_ack  output  1  one-cycle acknowledge of done.
- din  input  54  write beat: [53:50] byte mask, [49] frame, [48:32] word addr, [31:0] pixel data.
- din_valid  input  1  beat valid.
- din_ready  output  1  beat accepted when din_valid & din_ready.
- mem_valid  output  1  memory write command valid.
- mem_ready  input  1  memory accepts the command when mem_valid & mem_ready.
- mem_addr  output  MEM_ADDR_WIDTH  word address.
- mem_wdata  output  32  write data.
- mem_wmask  output  4  byte write enables.

Behaviour:
- Reset values: start=0, done_ack=0, busy=0, mem_valid=0, din_ready=1 (FIFO empty). FSM=IDLE, FIFO pointers and count cleared, stats cleared.
- A reset mid-pass abandons the pass immediately. Buffered beats are discarded and no further memory writes are issued.
- FSM states: IDLE, START, RUN, DRAIN, ACK.
  - IDLE: trigger=1 -> START.
  - START: start=1. Sampling start_ack=1 -> start=0 next cycle, go to RUN. Net effect: start is high for exactly 2 cycles when the generator registers start_ack.
  - RUN: on done=1 -> DRAIN.
  - DRAIN: on FIFO empty and no command pending on the memory port -> ACK.
  - ACK: done_ack=1 for exactly one cycle, then IDLE.
- trigger is ignored in every state other than IDLE. There is no queuing.
- din_ready = FIFO not full, in every state. A full FIFO blocks the push even if a pop occurs in the same cycle.
- Beats arriving outside START/RUN/DRAIN are still accepted and written.
- FIFO:
  - Registered write.
  - Head is visible on the memory port the cycle after the push, so the minimum latency from din accept to mem_valid is 1 cycle.
  - Beats leave in order. Pop on mem_valid & mem_ready. Simultaneous push and pop when not full leaves the count unchanged.
  - mem_valid = FIFO not empty. mem_addr, mem_wdata and mem_wmask are held stable while mem_valid=1 and mem_ready=0.
- Address rule: mem_addr = (frame ? FRAME1_BASE : FRAME0_BASE) + zero-extended 17-bit addr, computed modulo 2^MEM_ADDR_WIDTH.
- Pass-through rules: mem_wmask = din mask unchanged. An all-zero mask is still issued as a command. mem_wdata = pixel unchanged.
- done may rise on the same cycle as the last beat is accepted. That beat must still be written before done_ack.

Optional Feature:
- Macro OVERLAY_WRITER_STATS_EN.
- When defined:
  - Adds output pass_beats [16:0] and output pass_valid [0:0].
  - An internal counter counts memory writes issued (mem_valid & mem_ready) during the current pass. It clears on the IDLE->START transition.
  - In the ACK cycle the count is copied to pass_beats and pass_valid pulses high for 1 cycle.
  - pass_beats holds until the next ACK. Reset clears both outputs to 0.
- When not defined: the ports and counter do not exist. All other behaviour is identical.

Test Plan:
- Basic pass: generator model streaming 64 beats, mem_ready=1. trigger pulse -> start high 2 cycles; 64 writes in order with addr+FRAME*_BASE; done_ack single pulse after the last write; busy falls the cycle after ACK.
- Backpressure: mem_ready toggles 1 cycle in 4. -> FIFO fills to 8 and din_ready=0. No beat is lost or reordered. Command outputs are stable while stalled. done_ack is issued only after the FIFO is empty.
- Frame select:
  - Beat frame=1, addr=5 -> mem_addr=120005.
  - Beat frame=0, addr=5 -> mem_addr=5.
  - mask 4'b0100 and data 32'h02020202 pass through unchanged.
- Trigger while busy: second trigger during RUN -> ignored. Exactly one start sequence; no second pass after ACK.
- Reset mid-RUN with 5 beats buffered: reset for 1 cycle -> mem_valid=0, start=0, done_ack=0, busy=0 next cycle. No stale beats are written afterwards.
- Stats (OVERLAY_WRITER_STATS_EN): 64-beat pass -> pass_beats=64 with pass_valid pulse in the ACK cycle. A second pass of 64 again reports 64, not 128.
